pcw_mouse_accum: RTL and testbench

Upstream movement accumulator for the PCW AMX mouse port. It decodes the HPS PS/2 mouse packet stream into per-axis signed 9-bit accumulators, which it presents to the AMX port decoder as `mouse_x`/`mouse_y` with live button levels. When the AMX port decoder reads an axis register, the block removes exactly the quantised count that read reported, so sub-step residue is never lost.

---
 rtl/pcw_mouse_pkg.sv | 52 +++++
 rtl/pcw_mouse_axis.sv | 43 ++++
 rtl/pcw_mouse_accum.sv | 107 ++++++++++
 tb/tb_pcw_mouse_accum.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcw_mouse_pkg.sv
// Shared definitions for the PCW AMX mouse path: packet layout, accumulator range
// and the quantiser used by both this accumulator and the AMX port decoder.
package pcw_mouse_pkg;

    // HPS ps2_mouse packet bit positions
    localparam int unsigned PKT_BTN_L  = 0;
    localparam int unsigned PKT_BTN_R  = 1;
    localparam int unsigned PKT_BTN_M  = 2;
    localparam int unsigned PKT_X_SIGN = 4;
    localparam int unsigned PKT_Y_SIGN = 5;
    localparam int unsigned PKT_X_OVF  = 6;
    localparam int unsigned PKT_Y_OVF  = 7;
    localparam int unsigned PKT_X_LSB  = 8;
    localparam int unsigned PKT_Y_LSB  = 16;
    localparam int unsigned PKT_TOGGLE = 24;
    localparam int unsigned PKT_W      = 25;

    localparam int ACC_MIN = -256;
    localparam int ACC_MAX = 255;

    localparam logic signed [11:0] SAT_LO = 12'(ACC_MIN);
    localparam logic signed [11:0] SAT_HI = 12'(ACC_MAX);

    // Saturate a 12-bit working sum into the 9-bit accumulator range.
    function automatic logic signed [8:0] sat9(input logic signed [11:0] v);
        if (v < SAT_LO) begin
            return 9'(SAT_LO);
        end else if (v > SAT_HI) begin
            return 9'(SAT_HI);
        end
        return v[8:0];
    endfunction

    // AMX step count: trunc(acc / 8) toward zero, clamped to [-8, +7].
    function automatic logic signed [3:0] amx_quant(input logic signed [8:0] acc);
        logic signed [11:0] ext;
        logic signed [11:0] t;
        ext = {{3{acc[8]}}, acc};
        t   = ext >>> 3;
        // Arithmetic shift floors; bump negatives with a remainder back toward zero.
        if (acc[8] && (acc[2:0] != 3'b000)) begin
            t = t + 12'sd1;
        end
        if (t > 12'sd7) begin
            return 4'sd7;
        end else if (t < -12'sd8) begin
            return -4'sd8;
        end
        return t[3:0];
    endfunction

endpackage

// File: rtl/pcw_mouse_axis.sv
// One movement axis: saturating signed accumulator that adds packet deltas and
// removes exactly the quantised count reported to the AMX decoder on a read.
module pcw_mouse_axis
    import pcw_mouse_pkg::*;
(
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              pkt,
    input  logic signed [8:0] d,
    input  logic              rd,
    output logic signed [8:0] acc
);

    logic signed [8:0]  acc_q;
    logic signed [8:0]  acc_d;
    logic signed [3:0]  q;
    logic signed [11:0] sum;

    // Next accumulator: consume the step count the decoder latches now, add any packet.
    always_comb begin
        q   = amx_quant(acc_q);
        sum = {{3{acc_q[8]}}, acc_q};
        if (rd) begin
            sum = sum - {{5{q[3]}}, q, 3'b000};
        end
        if (pkt) begin
            sum = sum + {{3{d[8]}}, d};
        end
        acc_d = sat9(sum);
    end

    // Accumulator register.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/pcw_mouse_accum.sv
// PS/2 packet decoder and per-axis movement accumulators feeding the PCW AMX port.
module pcw_mouse_accum
    import pcw_mouse_pkg::*;
#(
    parameter bit INVERT_Y = 1'b1
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic [24:0]       ps2_mouse,
    input  logic              sel,
    input  logic [1:0]        addr,
    output logic signed [8:0] mouse_x,
    output logic signed [8:0] mouse_y,
    output logic              mouse_left,
    output logic              mouse_middle,
    output logic              mouse_right
);

    localparam logic signed [8:0] D_MIN = 9'sh100;
    localparam logic signed [8:0] D_MAX = 9'sh0ff;

    logic [PKT_W-1:0]  pkt_q;
    logic              tog_q;
    logic              old_sel_q;
    logic [2:0]        btn_q;
    logic              pkt;
    logic              rd;
    logic              rd_x;
    logic              rd_y;
    logic signed [8:0] dx;
    logic signed [8:0] dy_raw;
    logic signed [8:0] dy;
    logic              unused_status_b3;

    assign unused_status_b3 = pkt_q[3];

    function automatic logic signed [8:0] decode_delta(input logic       sign,
                                                       input logic       ovf,
                                                       input logic [7:0] mag);
        if (ovf) begin
            return sign ? D_MIN : D_MAX;
        end
        return {sign, mag};
    endfunction

    // Sample the packet and keep a delayed toggle copy for edge detection.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            pkt_q     <= '0;
            tog_q     <= 1'b0;
            old_sel_q <= 1'b0;
        end else begin
            pkt_q     <= ps2_mouse;
            tog_q     <= pkt_q[PKT_TOGGLE];
            old_sel_q <= sel;
        end
    end

    // Packet strobe, read strobes and decoded deltas.
    always_comb begin
        pkt    = pkt_q[PKT_TOGGLE] ^ tog_q;
        rd     = sel & ~old_sel_q;
        rd_x   = rd & (addr == 2'b01);
        rd_y   = rd & (addr == 2'b00);
        dx     = decode_delta(pkt_q[PKT_X_SIGN], pkt_q[PKT_X_OVF],
                              pkt_q[PKT_X_LSB +: 8]);
        dy_raw = decode_delta(pkt_q[PKT_Y_SIGN], pkt_q[PKT_Y_OVF],
                              pkt_q[PKT_Y_LSB +: 8]);
        dy     = dy_raw;
        if (INVERT_Y) begin
            // -(-256) does not fit in 9 bits; pin it to the positive limit.
            dy = (dy_raw == D_MIN) ? D_MAX : -dy_raw;
        end
    end

    // Button levels follow the most recent packet.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            btn_q <= '0;
        end else if (pkt) begin
            btn_q <= {pkt_q[PKT_BTN_L], pkt_q[PKT_BTN_M], pkt_q[PKT_BTN_R]};
        end
    end

    pcw_mouse_axis u_axis_x (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .pkt     (pkt),
        .d       (dx),
        .rd      (rd_x),
        .acc     (mouse_x)
    );

    pcw_mouse_axis u_axis_y (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .pkt     (pkt),
        .d       (dy),
        .rd      (rd_y),
        .acc     (mouse_y)
    );

    assign mouse_left   = btn_q[2];
    assign mouse_middle = btn_q[1];
    assign mouse_right  = btn_q[0];

endmodule

// File: tb/tb_pcw_mouse_accum.sv
// Scoreboard bench for pcw_mouse_accum: a behavioural model pushes expected
// outputs as stimulus is driven; each scenario pops and compares them.
module tb_pcw_mouse_accum;

    logic              clk_sys;
    logic              reset_n;
    logic [24:0]       ps2_mouse;
    logic              sel;
    logic [1:0]        addr;
    logic signed [8:0] mouse_x;
    logic signed [8:0] mouse_y;
    logic              mouse_left;
    logic              mouse_middle;
    logic              mouse_right;

    pcw_mouse_accum #(
        .INVERT_Y (1'b1)
    ) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .ps2_mouse    (ps2_mouse),
        .sel          (sel),
        .addr         (addr),
        .mouse_x      (mouse_x),
        .mouse_y      (mouse_y),
        .mouse_left   (mouse_left),
        .mouse_middle (mouse_middle),
        .mouse_right  (mouse_right)
    );

    typedef struct packed {
        logic signed [8:0] x;
        logic signed [8:0] y;
        logic [2:0]        btn;  // {left, middle, right}
    } exp_t;

    exp_t   sb[$];
    exp_t   e;
    logic [20:0] obs;
    int     n_checks = 0;
    int     n_errors = 0;

    // Model state
    int       mx = 0;
    int       my = 0;
    bit [2:0] mb = 3'b000;
    int       pdx = 0;
    int       pdy = 0;
    bit [2:0] pbtn = 3'b000;
    bit       tog = 1'b0;

    assign obs = {mouse_x, mouse_y, mouse_left, mouse_middle, mouse_right};

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int m_sat(input int v);
        if (v < -256) return -256;
        if (v > 255) return 255;
        return v;
    endfunction

    function automatic int m_quant(input int a);
        int t;
        t = a / 8;  // integer division truncates toward zero
        if (t > 7) t = 7;
        if (t < -8) t = -8;
        return t;
    endfunction

    function automatic int m_delta(input bit [7:0] mag, input bit s, input bit ovf);
        if (ovf) return s ? -256 : 255;
        return s ? int'(mag) - 256 : int'(mag);
    endfunction

    // Drive a new packet (toggle flips); the model update is deferred to m_apply.
    task automatic drive_pkt(input bit [7:0] xb, input bit xs, input bit xo,
                             input bit [7:0] yb, input bit ys, input bit yo,
                             input bit [2:0] btn_lmr);
        @(negedge clk_sys);
        tog = ~tog;
        ps2_mouse = {tog, yb, xb, yo, xo, ys, xs, 1'b1, btn_lmr[1], btn_lmr[0], btn_lmr[2]};
        pdx  = m_delta(xb, xs, xo);
        pdy  = m_delta(yb, ys, yo);
        pdy  = (pdy == -256) ? 255 : -pdy;
        pbtn = btn_lmr;
    endtask

    // Apply one model update (packet and/or read) and push the expected outputs.
    task automatic m_apply(input bit pk, input bit rdx, input bit rdy);
        int qx;
        int qy;
        exp_t n;
        qx = m_quant(mx);
        qy = m_quant(my);
        mx = m_sat(mx - (rdx ? 8 * qx : 0) + (pk ? pdx : 0));
        my = m_sat(my - (rdy ? 8 * qy : 0) + (pk ? pdy : 0));
        if (pk) mb = pbtn;
        n.x = mx[8:0];
        n.y = my[8:0];
        n.btn = mb;
        sb.push_back(n);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        ps2_mouse = '0;
        sel = 1'b0;
        addr = 2'b00;
        m_apply(1'b0, 1'b0, 1'b0);
        #12;
        e = sb.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_errors++;
            $display("FAIL reset_state: got x=%0d y=%0d btn=%b, want x=%0d y=%0d btn=%b",
                     mouse_x, mouse_y, obs[2:0], e.x, e.y, e.btn);
        end
        @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (2) @(negedge clk_sys);
    endtask

    task automatic test_single_packet;
        drive_pkt(8'h14, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'b000);
        m_apply(1'b0, 1'b0, 1'b0);  // one edge in: not yet visible
        m_apply(1'b1, 1'b0, 1'b0);
        @(negedge clk_sys);
        e = sb.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_errors++;
            $display("FAIL pkt_latency_1edge: got x=%0d y=%0d, want x=%0d y=%0d",
                     mouse_x, mouse_y, e.x, e.y);
        end
        @(negedge clk_sys);
        e = sb.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_errors++;
            $display("FAIL pkt_x20: got x=%0d y=%0d btn=%b, want x=%0d y=%0d btn=%b",
                     mouse_x, mouse_y, obs[2:0], e.x, e.y, e.btn);
        end
        sel = 1'b1;
        addr = 2'b01;
        m_apply(1'b0, 1'b1, 1'b0);
        @(negedge clk_sys);
        e = sb.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_errors++;
            $display("FAIL read_x: got x=%0d y=%0d, want x=%0d y=%0d",
                     mouse_x, mouse_y, e.x, e.y);
        end
        sel = 1'b0;
        @(negedge clk_sys);
    endtask

    task automatic test_neg_y;
        drive_pkt(8'h00, 1'b0, 1'b0, 8'hEC, 1'b1, 1'b0, 3'b010);
        m_apply(1'b1, 1'b0, 1'b0);
        repeat (2) @(negedge clk_sys);
        e = sb.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_errors++;
            $display("FAIL neg_y_invert: got x=%0d y=%0d btn=%b, want x=%0d y=%0d btn=%b",
                     mouse_x, mouse_y, obs[2:0], e.x, e.y, e.btn);
        end
        sel = 1'b1;
        addr = 2'b00;
        m_apply(1'b0, 1'b0, 1'b1);
        @(negedge clk_sys);
        e = sb.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_errors++;
            $display("FAIL read_y: got x=%0d y=%0d, want x=%0d y=%0d",
                     mouse_x, mouse_y, e.x, e.y);
        end
        sel = 1'b0;
        @(negedge clk_sys);
    endtask

    task automatic test_saturation;
        for (int i = 0; i < 5; i++) begin
            drive_pkt(8'd100, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'b001);
            m_apply(1'b1, 1'b0, 1'b0);
            repeat (2) @(negedge clk_sys);
            e = sb.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_errors++;
                $display("FAIL sat_step%0d: got x=%0d y=%0d btn=%b, want x=%0d y=%0d btn=%b",
                         i, mouse_x, mouse_y, obs[2:0], e.x, e.y, e.btn);
            end
        end
        drive_pkt(8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 3'b000);
        m_apply(1'b1, 1'b0, 1'b0);
        repeat (2) @(negedge clk_sys);
        e = sb.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_errors++;
            $display("FAIL x_overflow_neg: got x=%0d y=%0d, want x=%0d y=%0d",
                     mouse_x, mouse_y, e.x, e.y);
        end
    endtask

    task automatic test_simultaneous;
        logic [8:0] dv;
        int delta;
        delta = 60 - mx;
        dv = delta[8:0];
        drive_pkt(dv[7:0], dv[8], 1'b0, 8'h00, 1'b0, 1'b0, 3'b000);
        m_apply(1'b1, 1'b0, 1'b0);
        repeat (2) @(negedge clk_sys);
        e = sb.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_errors++;
            $display("FAIL preload_x60: got x=%0d, want x=%0d", mouse_x, e.x);
        end
        drive_pkt(8'd5, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'b000);
        @(negedge clk_sys);
        sel = 1'b1;
        addr = 2'b01;
        m_apply(1'b1, 1'b1, 1'b0);
        @(negedge clk_sys);
        e = sb.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_errors++;
            $display("FAIL pkt_and_read: got x=%0d y=%0d, want x=%0d y=%0d",
                     mouse_x, mouse_y, e.x, e.y);
        end
        sel = 1'b0;
        @(negedge clk_sys);
    endtask

    task automatic test_no_double_count;
        drive_pkt(8'd30, 1'b0, 1'b0, 8'd3, 1'b0, 1'b0, 3'b100);
        m_apply(1'b1, 1'b0, 1'b0);
        m_apply(1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk_sys);
        e = sb.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_errors++;
            $display("FAIL pkt_pre_hold: got x=%0d y=%0d, want x=%0d y=%0d",
                     mouse_x, mouse_y, e.x, e.y);
        end
        repeat (100) @(negedge clk_sys);
        e = sb.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_errors++;
            $display("FAIL toggle_held: got x=%0d y=%0d, want x=%0d y=%0d",
                     mouse_x, mouse_y, e.x, e.y);
        end
        sel = 1'b1;
        addr = 2'b01;
        m_apply(1'b0, 1'b1, 1'b0);
        repeat (10) @(negedge clk_sys);
        e = sb.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_errors++;
            $display("FAIL sel_held: got x=%0d y=%0d, want x=%0d y=%0d",
                     mouse_x, mouse_y, e.x, e.y);
        end
        sel = 1'b0;
        @(negedge clk_sys);
        sel = 1'b1;
        addr = 2'b10;
        m_apply(1'b0, 1'b0, 1'b0);
        @(negedge clk_sys);
        e = sb.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_errors++;
            $display("FAIL addr10_read: got x=%0d y=%0d, want x=%0d y=%0d",
                     mouse_x, mouse_y, e.x, e.y);
        end
        sel = 1'b0;
        @(negedge clk_sys);
    endtask

    task automatic test_reset_mid;
        logic [8:0] dv;
        int delta;
        delta = -37 - mx;
        dv = delta[8:0];
        drive_pkt(dv[7:0], dv[8], 1'b0, 8'h00, 1'b0, 1'b0, 3'b100);
        m_apply(1'b1, 1'b0, 1'b0);
        repeat (2) @(negedge clk_sys);
        e = sb.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_errors++;
            $display("FAIL preload_m37: got x=%0d btn=%b, want x=%0d btn=%b",
                     mouse_x, obs[2:0], e.x, e.btn);
        end
        @(posedge clk_sys);
        #2;
        reset_n = 1'b0;
        ps2_mouse = '0;
        tog = 1'b0;
        mx = 0;
        my = 0;
        mb = 3'b000;
        m_apply(1'b0, 1'b0, 1'b0);
        #1;
        e = sb.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_errors++;
            $display("FAIL async_reset: got x=%0d y=%0d btn=%b, want x=%0d y=%0d btn=%b",
                     mouse_x, mouse_y, obs[2:0], e.x, e.y, e.btn);
        end
        @(posedge clk_sys);
        #2;
        reset_n = 1'b1;
        m_apply(1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk_sys);
        e = sb.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_errors++;
            $display("FAIL post_reset_idle: got x=%0d y=%0d, want x=%0d y=%0d",
                     mouse_x, mouse_y, e.x, e.y);
        end
        drive_pkt(8'd3, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'b000);
        m_apply(1'b1, 1'b0, 1'b0);
        repeat (2) @(negedge clk_sys);
        e = sb.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_errors++;
            $display("FAIL post_reset_pkt: got x=%0d y=%0d, want x=%0d y=%0d",
                     mouse_x, mouse_y, e.x, e.y);
        end
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_neg_y();
        test_saturation();
        test_simultaneous();
        test_no_double_count();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
